// File: rtl/sva_collect_pkg.sv
// Shared types for the SVA result collector: result kinds, record layout,
// verdict encoding, control FSM states and the verdict rule.
package sva_collect_pkg;

    typedef struct packed {
        logic lazy;
        logic fail;
        logic succ;
    } evt_kind_t;

    // Record layout at the default 32-bit timestamp width.
    localparam int REC_TS_W = 32;

    typedef struct packed {
        evt_kind_t             kind;
        logic [REC_TS_W-1:0]   stamp;
    } evt_rec_t;

    typedef enum logic [1:0] {
        V_NONE = 2'd0,
        V_PASS = 2'd1,
        V_FAIL = 2'd2
    } verdict_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2,
        ST_DONE = 2'd3
    } collect_fsm_t;

    // Any failure loses; otherwise the success quota decides.
    function automatic verdict_t judge(input logic any_fail, input logic succ_met);
        if (any_fail)
            judge = V_FAIL;
        else if (succ_met)
            judge = V_PASS;
        else
            judge = V_FAIL;
    endfunction

endpackage

// File: rtl/sva_evt_fifo.sv
// DEPTH-entry record FIFO (kind + timestamp); accepts a push while full when
// the head is popped in the same cycle.
module sva_evt_fifo
    import sva_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 32
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic            push,
    input  logic [2:0]      push_kind,
    input  logic [TS_W-1:0] push_time,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [2:0]      head_kind,
    output logic [TS_W-1:0] head_time
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer bit distinguishes full from empty.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [2:0]      kind_mem [DEPTH];
    logic [TS_W-1:0] time_mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge gclk) begin
        if (push) begin
            kind_mem[wr_ptr[AW-1:0]] <= push_kind;
            time_mem[wr_ptr[AW-1:0]] <= push_time;
        end
    end

    assign head_kind = kind_mem[rd_ptr[AW-1:0]];
    assign head_time = time_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sva_result_collector.sv
// Timestamps, tallies and buffers SVA checker results and issues the verdict.
// Optional macro SVA_COLLECT_FIRST_FAIL_EN adds first-fail timestamp capture.
module sva_result_collector
    import sva_collect_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int TS_W       = 32,
    parameter int CNT_W      = 16,
    parameter int FAIL_LIMIT = 1,
    parameter int MIN_SUCC   = 1
) (
    input  logic             gclk,
    input  logic             grst,
    input  logic             succ_i,
    input  logic             fail_i,
    input  logic             lazy_succ_i,
    input  logic             eot_i,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [2:0]       rpt_kind_o,
    output logic [TS_W-1:0]  rpt_time_o,
    output logic [CNT_W-1:0] succ_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] lazy_cnt_o,
    output logic             ovf_o,
    output logic             stop_req_o,
    output logic [1:0]       verdict_o,
    output logic             done_o
`ifdef SVA_COLLECT_FIRST_FAIL_EN
    ,
    output logic             first_fail_valid_o,
    output logic [TS_W-1:0]  first_fail_time_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] FAIL_LIM_C = CNT_W'(FAIL_LIMIT);
    localparam logic [CNT_W-1:0] MIN_SUCC_C = CNT_W'(MIN_SUCC);

    collect_fsm_t     state;
    collect_fsm_t     state_nx;
    evt_kind_t        kind;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] succ_q, fail_q, lazy_q;
    logic [CNT_W-1:0] succ_nx, fail_nx, lazy_nx;
    logic             active, evt, push, pop, full, empty, limit_hit;
    logic             ovf_q, stop_q;
    verdict_t         verdict_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        sat_inc = (en && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    assign kind      = {lazy_succ_i, fail_i, succ_i};
    assign active    = (state != ST_DONE);
    assign evt       = active && (|kind);
    assign pop       = !empty && rpt_ready_i;
    // A full FIFO still takes the record if the head leaves this cycle.
    assign push      = evt && (!full || pop);
    assign succ_nx   = sat_inc(succ_q, active && succ_i);
    assign fail_nx   = sat_inc(fail_q, active && fail_i);
    assign lazy_nx   = sat_inc(lazy_q, active && lazy_succ_i);
    assign limit_hit = (fail_nx >= FAIL_LIM_C);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // eot wins over every other transition; the eot cycle's event is still counted.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (eot_i)
                    state_nx = ST_DONE;
                else if (evt)
                    state_nx = limit_hit ? ST_FAIL : ST_RUN;
            end
            ST_RUN: begin
                if (eot_i)
                    state_nx = ST_DONE;
                else if (limit_hit)
                    state_nx = ST_FAIL;
            end
            ST_FAIL: begin
                if (eot_i)
                    state_nx = ST_DONE;
            end
            default: state_nx = ST_DONE;
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            ts_q      <= '0;
            succ_q    <= '0;
            fail_q    <= '0;
            lazy_q    <= '0;
            ovf_q     <= 1'b0;
            stop_q    <= 1'b0;
            verdict_q <= V_NONE;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            succ_q <= succ_nx;
            fail_q <= fail_nx;
            lazy_q <= lazy_nx;
            if (evt && !push)
                ovf_q <= 1'b1;
            if (active && limit_hit)
                stop_q <= 1'b1;
            if (active && (state_nx == ST_DONE))
                verdict_q <= judge(fail_nx != '0, succ_nx >= MIN_SUCC_C);
        end
    end

`ifdef SVA_COLLECT_FIRST_FAIL_EN
    logic            ff_valid_q;
    logic [TS_W-1:0] ff_time_q;

    // Captures dropped fail records too, since it looks at the raw flag.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            ff_valid_q <= 1'b0;
            ff_time_q  <= '0;
        end else if (active && fail_i && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_time_q  <= ts_q;
        end
    end

    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_time_o  = ff_time_q;
`else
    // First-fail capture is not built in this configuration.
`endif

    sva_evt_fifo #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) u_fifo (
        .gclk      (gclk),
        .grst      (grst),
        .push      (push),
        .push_kind (kind),
        .push_time (ts_q),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_kind (rpt_kind_o),
        .head_time (rpt_time_o)
    );

    assign rpt_valid_o = !empty;
    assign succ_cnt_o  = succ_q;
    assign fail_cnt_o  = fail_q;
    assign lazy_cnt_o  = lazy_q;
    assign ovf_o       = ovf_q;
    assign stop_req_o  = stop_q;
    assign verdict_o   = verdict_q;
    assign done_o      = (state == ST_DONE);

endmodule

// File: tb/tb_sva_result_collector.sv
// Bench for sva_result_collector: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_sva_result_collector;

    localparam int DEPTH      = 8;
    localparam int TS_W       = 32;
    localparam int CNT_W      = 16;
    localparam int FAIL_LIMIT = 1;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic gclk = 1'b0;
    logic grst = 1'b1;
    logic succ_i = 1'b0, fail_i = 1'b0, lazy_succ_i = 1'b0, eot_i = 1'b0, rpt_ready_i = 1'b0;

    logic             rpt_valid_o;
    logic [2:0]       rpt_kind_o;
    logic [TS_W-1:0]  rpt_time_o;
    logic [CNT_W-1:0] succ_cnt_o, fail_cnt_o, lazy_cnt_o;
    logic             ovf_o, stop_req_o, done_o;
    logic [1:0]       verdict_o;

    // Second instance with MIN_SUCC=0 sees identical stimulus.
    logic             z_valid;
    logic [2:0]       z_kind;
    logic [TS_W-1:0]  z_time;
    logic [CNT_W-1:0] z_succ, z_fail, z_lazy;
    logic             z_ovf, z_stop, z_done;
    logic [1:0]       z_verdict;

`ifdef SVA_COLLECT_FIRST_FAIL_EN
    logic            ffv, z_ffv;
    logic [TS_W-1:0] fft, z_fft;
`endif

    sva_result_collector #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W),
                           .FAIL_LIMIT(FAIL_LIMIT), .MIN_SUCC(1)) dut (
        .gclk(gclk), .grst(grst), .succ_i(succ_i), .fail_i(fail_i),
        .lazy_succ_i(lazy_succ_i), .eot_i(eot_i), .rpt_valid_o(rpt_valid_o),
        .rpt_ready_i(rpt_ready_i), .rpt_kind_o(rpt_kind_o), .rpt_time_o(rpt_time_o),
        .succ_cnt_o(succ_cnt_o), .fail_cnt_o(fail_cnt_o), .lazy_cnt_o(lazy_cnt_o),
        .ovf_o(ovf_o), .stop_req_o(stop_req_o), .verdict_o(verdict_o), .done_o(done_o)
`ifdef SVA_COLLECT_FIRST_FAIL_EN
        , .first_fail_valid_o(ffv), .first_fail_time_o(fft)
`endif
    );

    sva_result_collector #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W),
                           .FAIL_LIMIT(FAIL_LIMIT), .MIN_SUCC(0)) dut_ms0 (
        .gclk(gclk), .grst(grst), .succ_i(succ_i), .fail_i(fail_i),
        .lazy_succ_i(lazy_succ_i), .eot_i(eot_i), .rpt_valid_o(z_valid),
        .rpt_ready_i(rpt_ready_i), .rpt_kind_o(z_kind), .rpt_time_o(z_time),
        .succ_cnt_o(z_succ), .fail_cnt_o(z_fail), .lazy_cnt_o(z_lazy),
        .ovf_o(z_ovf), .stop_req_o(z_stop), .verdict_o(z_verdict), .done_o(z_done)
`ifdef SVA_COLLECT_FIRST_FAIL_EN
        , .first_fail_valid_o(z_ffv), .first_fail_time_o(z_fft)
`endif
    );

    always #5 gclk = ~gclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: records in a queue, tallies as plain integers.
    typedef struct {
        logic [2:0]  kind;
        int unsigned t;
    } rec_t;

    rec_t        m_q[$];
    int unsigned m_ts;
    int          m_succ, m_fail, m_lazy;
    bit          m_ovf, m_done;
    int          m_verdict, m_verdict0;
    bit          m_ffv;
    int unsigned m_fft;

    task automatic model_clear();
        m_q.delete();
        m_ts = 0; m_succ = 0; m_fail = 0; m_lazy = 0;
        m_ovf = 0; m_done = 0; m_verdict = 0; m_verdict0 = 0;
        m_ffv = 0; m_fft = 0;
    endtask

    function automatic int bump(input int c);
        return (c < CNT_SAT) ? c + 1 : c;
    endfunction

    task automatic check_all();
        chk("valid", rpt_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("kind", rpt_kind_o, m_q[0].kind);
            chk("time", rpt_time_o, m_q[0].t);
        end
        chk("succ_cnt", succ_cnt_o, m_succ);
        chk("fail_cnt", fail_cnt_o, m_fail);
        chk("lazy_cnt", lazy_cnt_o, m_lazy);
        chk("ovf", ovf_o, m_ovf);
        chk("stop_req", stop_req_o, m_fail >= FAIL_LIMIT);
        chk("done", done_o, m_done);
        chk("verdict", verdict_o, m_verdict);
        chk("done_ms0", z_done, m_done);
        chk("verdict_ms0", z_verdict, m_verdict0);
`ifdef SVA_COLLECT_FIRST_FAIL_EN
        chk("ff_valid", ffv, m_ffv);
        if (m_ffv)
            chk("ff_time", fft, m_fft);
`endif
    endtask

    // One clock: drive at negedge, advance the model across the posedge, check at next negedge.
    task automatic step(input logic s, input logic f, input logic l, input logic e, input logic r);
        bit         do_pop;
        logic [2:0] k;
        rec_t       rc;
        succ_i = s; fail_i = f; lazy_succ_i = l; eot_i = e; rpt_ready_i = r;
        do_pop = (m_q.size() > 0) && r;
        @(posedge gclk);
        if (do_pop)
            void'(m_q.pop_front());
        if (!m_done) begin
            k = {l, f, s};
            if (k != 3'b000) begin
                if (s) m_succ = bump(m_succ);
                if (f) m_fail = bump(m_fail);
                if (l) m_lazy = bump(m_lazy);
                if (f && !m_ffv) begin
                    m_ffv = 1;
                    m_fft = m_ts;
                end
                if (m_q.size() < DEPTH) begin
                    rc.kind = k;
                    rc.t    = m_ts;
                    m_q.push_back(rc);
                end else begin
                    m_ovf = 1;
                end
            end
            if (e) begin
                m_done     = 1;
                m_verdict  = (m_fail > 0) ? 2 : ((m_succ >= 1) ? 1 : 2);
                m_verdict0 = (m_fail > 0) ? 2 : 1;
            end
        end
        m_ts = m_ts + 1;
        @(negedge gclk);
        check_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, r);
    endtask

    // Called at a negedge; checks the asynchronous clear before any clock edge.
    task automatic do_reset();
        grst = 1'b1;
        #1;
        chk("rst_valid", rpt_valid_o, 0);
        chk("rst_succ", succ_cnt_o, 0);
        chk("rst_fail", fail_cnt_o, 0);
        chk("rst_lazy", lazy_cnt_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_stop", stop_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_verdict", verdict_o, 0);
        succ_i = 0; fail_i = 0; lazy_succ_i = 0; eot_i = 0; rpt_ready_i = 0;
        model_clear();
        @(negedge gclk);
        grst = 1'b0;
        check_all();
    endtask

    initial begin
        model_clear();
        @(negedge gclk);
        do_reset();

        // Two successes at ts 3 and 7, eot at ts 10.
        idle(3, 1);
        step(1, 0, 0, 0, 1);
        chk("t1_rec0_time", rpt_time_o, 3);
        idle(3, 1);
        step(1, 0, 0, 0, 1);
        chk("t1_rec1_time", rpt_time_o, 7);
        idle(2, 1);
        step(0, 0, 0, 1, 1);
        chk("t1_succ", succ_cnt_o, 2);
        chk("t1_done", done_o, 1);
        chk("t1_verdict", verdict_o, 1);
        step(1, 1, 1, 1, 1);
        chk("t1_frozen", succ_cnt_o, 2);
        chk("t1_frozen_valid", rpt_valid_o, 0);

        // Fail at ts 5 requests stop one cycle later.
        do_reset();
        idle(5, 1);
        step(0, 1, 0, 0, 1);
        chk("t2_stop", stop_req_o, 1);
        idle(2, 1);
        step(0, 0, 0, 1, 1);
        chk("t2_verdict", verdict_o, 2);

        // Ten events into an 8-deep FIFO with the consumer stalled, then drain.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 0, 0, 0, 0);
        chk("t3_ovf", ovf_o, 1);
        chk("t3_succ", succ_cnt_o, 10);
        chk("t3_head_time", rpt_time_o, 0);
        idle(10, 1);
        chk("t3_drained", rpt_valid_o, 0);

        // Simultaneous succ and lazy at ts 4.
        do_reset();
        idle(4, 0);
        step(1, 0, 1, 0, 0);
        chk("t4_kind", rpt_kind_o, 3'b101);
        chk("t4_time", rpt_time_o, 4);
        idle(2, 1);

        // eot with no events: MIN_SUCC 1 fails, MIN_SUCC 0 passes.
        do_reset();
        idle(2, 1);
        step(0, 0, 0, 1, 1);
        chk("t5_verdict_ms1", verdict_o, 2);
        chk("t5_verdict_ms0", z_verdict, 1);

        // Reset with three pending records; timestamp restarts at zero.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 0, 0);
        do_reset();
        step(0, 1, 0, 0, 0);
        chk("t6_time", rpt_time_o, 0);
        idle(2, 1);

        // Random traffic with occasional eot and varied consumer pressure.
        for (int rnd = 0; rnd < 24; rnd++) begin
            int eot_at;
            int rdy_pct;
            do_reset();
            eot_at  = $urandom_range(5, 70);
            rdy_pct = $urandom_range(0, 3) * 30 + 10;
            for (int c = 0; c < 80; c++) begin
                logic s, f, l, e, r;
                s = ($urandom_range(0, 2) == 0);
                f = ($urandom_range(0, 9) == 0);
                l = ($urandom_range(0, 3) == 0);
                e = (c == eot_at) || ($urandom_range(0, 199) == 0);
                r = ($urandom_range(0, 99) < rdy_pct);
                step(s, f, l, e, r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
